ncl_quat_rx: RTL and testbench

Clocked receiver for a 1-of-4 (quaternary) NCL link, such as the output of the binary+trinary quaternary adder. It synchronizes the four asynchronous data rails into the `clk` domain and filters them for stability. It accepts each complete DATA wavefront, decodes it to a 2-bit value and queues it in a small FIFO behind a valid/ready port. It drives the completion/acknowledge signal back to the NCL side, which enforces DATA/NULL alternation and back-pressure.

---
 rtl/ncl_quat_pkg.sv | 29 ++
 rtl/ncl_rail_sync.sv | 52 +++++
 rtl/ncl_quat_rx.sv | 144 ++++++++++++++
 tb/tb_ncl_quat_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_quat_pkg.sv
// Shared types and helpers for the 1-of-4 NCL receiver.
//   state_e      : handshake FSM states
//   QUAT_NULL    : all-rails-low (NULL) pattern
//   quat_onehot  : true when exactly one rail is high
//   quat_decode  : index of the high rail (valid only for one-hot input)
package ncl_quat_pkg;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_e;

  localparam logic [3:0] QUAT_NULL = 4'b0000;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic quat_onehot(input logic [3:0] v);
    return (v != QUAT_NULL) && ((v & (v - 4'd1)) == QUAT_NULL);
  endfunction

  function automatic logic [1:0] quat_decode(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ncl_rail_sync.sv
// Multi-flop synchronizer for a vector of NCL rails plus a stability filter.
//   clk, rst_n  : clock, async active-low reset
//   i_rails     : asynchronous rail vector
//   o_vec       : synchronized rail vector (registered)
//   o_stable_c  : o_vec has been unchanged for STABLE consecutive samples
module ncl_rail_sync #(
  parameter int unsigned W           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_rails,
  output logic [W-1:0] o_vec,
  output logic         o_stable_c
);

  localparam int unsigned CNTW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [CNTW-1:0] STABLE_C = CNTW'(STABLE);

  logic [W-1:0]    r_sync [SYNC_STAGES];
  logic [CNTW-1:0] r_cnt;
  logic            w_change;

  // The last stage is about to take a value different from its current one.
  assign w_change = (r_sync[SYNC_STAGES-2] != r_sync[SYNC_STAGES-1]);

  // Synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_rails;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Counts samples of the last stage since it last changed, saturating at STABLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_change) begin
      r_cnt <= CNTW'(1);
    end else if (r_cnt != STABLE_C) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign o_vec      = r_sync[SYNC_STAGES-1];
  assign o_stable_c = (r_cnt == STABLE_C);

endmodule

// File: rtl/ncl_quat_rx.sv
// Clocked receiver for a 1-of-4 NCL link: filters the rails, runs the
// DATA/NULL handshake, queues decoded values in a FIFO, counts illegal patterns.
//   clk, init_n : clock, async active-low reset
//   quat        : NCL rails (async); quatack : completion back to the source
//   q_data/q_valid/q_ready : decoded-value output stream
//   err/err_cnt/err_clr    : sticky illegal-pattern flag, saturating count, clear
module ncl_quat_rx
  import ncl_quat_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE      = 2,
  parameter int unsigned DEPTH       = 2
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [3:0] quat,
  output logic       quatack,
  output logic [1:0] q_data,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       err,
  output logic [7:0] err_cnt,
  input  logic       err_clr
);

  localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [3:0]    w_vec;
  logic          w_stable;
  state_e        r_state, w_state_nxt;
  logic          w_push, w_err_evt, w_pop;
  logic          r_ack;
  logic [1:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [CW-1:0] r_count, w_count_nxt, w_remain;
  logic [1:0]    r_qdata;
  logic          r_qvalid;
  logic          r_err;
  logic [7:0]    r_err_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  ncl_rail_sync #(
    .W           (4),
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE      (STABLE)
  ) u_sync (
    .clk        (clk),
    .rst_n      (init_n),
    .i_rails    (quat),
    .o_vec      (w_vec),
    .o_stable_c (w_stable)
  );

  // Handshake decisions; full check uses the registered count only.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_stable) begin
          if (quat_onehot(w_vec)) begin
            if (r_count != DEPTH_C) begin
              w_push      = 1'b1;
              w_state_nxt = WAIT_NULL;
            end
          end else if (w_vec != QUAT_NULL) begin
            w_err_evt   = 1'b1;
            w_state_nxt = WAIT_NULL;
          end
        end
      end
      WAIT_NULL: begin
        if (w_stable && (w_vec == QUAT_NULL)) w_state_nxt = WAIT_DATA;
      end
      default: w_state_nxt = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state <= WAIT_DATA;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == WAIT_NULL);
    end
  end

  // FIFO bookkeeping. Entries pushed this cycle become visible one edge later,
  // so the next head is taken from entries already stored (count minus pop).
  assign w_pop       = r_qvalid & q_ready;
  assign w_rptr_nxt  = w_pop ? ptr_inc(r_rptr) : r_rptr;
  assign w_remain    = r_count - CW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= quat_decode(w_vec);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_qvalid <= 1'b0;
      r_qdata  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_qvalid <= (w_remain != '0);
      if (w_remain != '0) r_qdata <= r_mem[w_rptr_nxt];
    end
  end

  // Error flag and saturating counter; an error event beats a same-cycle clear.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
      if (err_clr)                r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end
  end

  assign quatack = r_ack;
  assign q_data  = r_qdata;
  assign q_valid = r_qvalid;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ncl_quat_rx.sv
module tb_ncl_quat_rx;

  logic       clk = 1'b0;
  logic       init_n;
  logic [3:0] quat;
  logic       quatack;
  logic [1:0] q_data;
  logic       q_valid;
  logic       q_ready;
  logic       err;
  logic [7:0] err_cnt;
  logic       err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ncl_quat_rx #(
    .SYNC_STAGES (2),
    .STABLE      (2),
    .DEPTH       (2)
  ) dut (
    .clk     (clk),
    .init_n  (init_n),
    .quat    (quat),
    .quatack (quatack),
    .q_data  (q_data),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .err     (err),
    .err_cnt (err_cnt),
    .err_clr (err_clr)
  );

  // One rising edge, then settle 1ns before driving/sampling.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until quatack reaches lvl; returns the budget if it never does.
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    while (quatack !== lvl && n < 20) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset;
    init_n = 1'b0; quat = 4'b0000; q_ready = 1'b0; err_clr = 1'b0;
    step(3);
    init_n = 1'b1;
    step(3);
    n_cmp++; if (quatack !== 1'b0) begin n_fail++; $display("FAIL reset_quatack got=%b exp=0", quatack); end
    n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
    n_cmp++; if (q_data !== 2'd0) begin n_fail++; $display("FAIL reset_q_data got=%0d exp=0", q_data); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_sequence;
    logic [1:0] vals [3];
    int n;
    vals[0] = 2'd2; vals[1] = 2'd0; vals[2] = 2'd3;
    q_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      quat = 4'b0001 << vals[i];
      wait_ack(1'b1, n);
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL seq_ack_rise[%0d] got=%0d edges exp=4", i, n); end
      step(1);
      n_cmp++; if (q_valid !== 1'b1 || q_data !== vals[i]) begin
        n_fail++; $display("FAIL seq_data[%0d] got valid=%b data=%0d exp valid=1 data=%0d", i, q_valid, q_data, vals[i]);
      end
      quat = 4'b0000;
      wait_ack(1'b0, n);
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL seq_ack_fall[%0d] got=%0d edges exp=4", i, n); end
      n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL seq_popped[%0d] got valid=%b exp=0", i, q_valid); end
    end
    q_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    q_ready = 1'b0;
    quat = 4'b0010; wait_ack(1'b1, n); quat = 4'b0000; wait_ack(1'b0, n);
    quat = 4'b1000; wait_ack(1'b1, n); quat = 4'b0000; wait_ack(1'b0, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL bp_second_fall got=%0d edges exp=4", n); end
    quat = 4'b0100;
    step(10);
    n_cmp++; if (quatack !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ack got=%b exp=0", quatack); end
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd1) begin
      n_fail++; $display("FAIL bp_head got valid=%b data=%0d exp valid=1 data=1", q_valid, q_data);
    end
    q_ready = 1'b1;
    step(1);
    n_cmp++; if (q_data !== 2'd3 || quatack !== 1'b0) begin
      n_fail++; $display("FAIL bp_pop got data=%0d ack=%b exp data=3 ack=0", q_data, quatack);
    end
    step(1);
    n_cmp++; if (quatack !== 1'b1) begin n_fail++; $display("FAIL bp_third_push got ack=%b exp=1", quatack); end
    step(1);
    q_ready = 1'b0;
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd2) begin
      n_fail++; $display("FAIL bp_third_head got valid=%b data=%0d exp valid=1 data=2", q_valid, q_data);
    end
    quat = 4'b0000;
    wait_ack(1'b0, n);
    q_ready = 1'b1;
    step(2);
    q_ready = 1'b0;
    n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got valid=%b exp=0", q_valid); end
  endtask

  task automatic test_glitch;
    quat = 4'b0010;
    step(1);
    quat = 4'b0000;
    step(10);
    n_cmp++; if (quatack !== 1'b0) begin n_fail++; $display("FAIL glitch_ack got=%b exp=0", quatack); end
    n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_push got valid=%b exp=0", q_valid); end
  endtask

  task automatic test_push_pop;
    int n;
    q_ready = 1'b0;
    quat = 4'b0010; wait_ack(1'b1, n); quat = 4'b0000; wait_ack(1'b0, n);
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd1) begin
      n_fail++; $display("FAIL pp_one_entry got valid=%b data=%0d exp valid=1 data=1", q_valid, q_data);
    end
    quat = 4'b1000;
    step(3);
    q_ready = 1'b1;
    step(1);
    q_ready = 1'b0;
    n_cmp++; if (quatack !== 1'b1) begin n_fail++; $display("FAIL pp_push_ack got=%b exp=1", quatack); end
    step(1);
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd3) begin
      n_fail++; $display("FAIL pp_new_head got valid=%b data=%0d exp valid=1 data=3", q_valid, q_data);
    end
    q_ready = 1'b1;
    step(1);
    q_ready = 1'b0;
    n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL pp_count_one got valid=%b exp=0", q_valid); end
    quat = 4'b0000;
    wait_ack(1'b0, n);
  endtask

  task automatic test_error;
    int n;
    quat = 4'b0110;
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL err_ack_rise got=%0d edges exp=4", n); end
    n_cmp++; if (err !== 1'b1 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL err_first got err=%b cnt=%0d exp err=1 cnt=1", err, err_cnt);
    end
    step(1);
    n_cmp++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_push got valid=%b exp=0", q_valid); end
    quat = 4'b0000;
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL err_ack_fall got=%0d edges exp=4", n); end
    for (int i = 0; i < 255; i++) begin
      quat = (i % 2 == 0) ? 4'b1001 : 4'b1111;
      wait_ack(1'b1, n);
      quat = 4'b0000;
      wait_ack(1'b0, n);
    end
    n_cmp++; if (err_cnt !== 8'd255 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_saturate got err=%b cnt=%0d exp err=1 cnt=255", err, err_cnt);
    end
    quat = 4'b1100;
    step(3);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b1 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL err_clr_vs_event got err=%b cnt=%0d exp err=1 cnt=1", err, err_cnt);
    end
    quat = 4'b0000;
    wait_ack(1'b0, n);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL err_clear got err=%b cnt=%0d exp err=0 cnt=0", err, err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    q_ready = 1'b0;
    quat = 4'b0100;
    wait_ack(1'b1, n);
    step(1);
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd2 || quatack !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got valid=%b data=%0d ack=%b exp 1/2/1", q_valid, q_data, quatack);
    end
    #2;
    init_n = 1'b0;
    #1;
    n_cmp++; if (quatack !== 1'b0 || q_valid !== 1'b0 || q_data !== 2'd0) begin
      n_fail++; $display("FAIL rst_async got ack=%b valid=%b data=%0d exp 0/0/0", quatack, q_valid, q_data);
    end
    n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_err got err=%b cnt=%0d exp 0/0", err, err_cnt);
    end
    step(3);
    init_n = 1'b1;
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL rst_reaccept got=%0d edges exp=4", n); end
    step(1);
    n_cmp++; if (q_valid !== 1'b1 || q_data !== 2'd2) begin
      n_fail++; $display("FAIL rst_requeue got valid=%b data=%0d exp valid=1 data=2", q_valid, q_data);
    end
    quat = 4'b0000;
    q_ready = 1'b1;
    wait_ack(1'b0, n);
    q_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_backpressure;
    test_glitch;
    test_push_pop;
    test_error;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
